// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit controller.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 5208;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } state_e;

endpackage

// File: rtl/parity_calc.sv
// Registered parity generator: par_bit = XOR of data, inverted when par_typ (odd) is set.
module parity_calc (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_valid,
    input  logic [7:0] data,
    input  logic       par_typ,
    output logic       par_bit
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bit <= 1'b0;
        end else if (data_valid) begin
            par_bit <= (^data) ^ par_typ;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit framing controller around an external serializer.
// Define UART_PARITY_EN to add the par_typ port and a parity bit (11-bit frames).
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT      = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned CLK_COUNTER_WIDTH = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_valid,
    input  logic [7:0] p_data_in,
`ifdef UART_PARITY_EN
    input  logic       par_typ,
`endif
    input  logic       ser_data,
    input  logic       ser_done,
    output logic       ser_en,
    output logic [7:0] p_data,
    output logic       tx_out,
    output logic       busy
);

    state_e                       state_q, state_d;
    logic [CLK_COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [7:0]                   p_data_q, p_data_d;
    logic                         busy_q, busy_d;
    logic                         tx_out_q, tx_out_d;
    logic                         accept;
    logic                         bit_end;

    assign accept  = (state_q == StIdle) && data_valid;
    assign bit_end = (cnt_q == CLK_COUNTER_WIDTH'(CLKS_PER_BIT - 1));

`ifdef UART_PARITY_EN
    logic par_bit;

    parity_calc u_parity_calc (
        .clk        (clk),
        .rst        (rst),
        .data_valid (accept),
        .data       (p_data_in),
        .par_typ    (par_typ),
        .par_bit    (par_bit)
    );
`endif

    always_comb begin
        state_d  = state_q;
        p_data_d = p_data_q;
        busy_d   = busy_q;
        tx_out_d = IDLE_LVL;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d  = StStart;
                    p_data_d = p_data_in;
                    busy_d   = 1'b1;
                end
            end
            StStart: begin
                tx_out_d = START_LVL;
                if (bit_end) state_d = StData;
            end
            StData: begin
                tx_out_d = ser_data;
                if (ser_done) begin
`ifdef UART_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StStop;
`endif
                end
            end
`ifdef UART_PARITY_EN
            StParity: begin
                tx_out_d = par_bit;
                if (bit_end) state_d = StStop;
            end
`endif
            StStop: begin
                tx_out_d = STOP_LVL;
                if (bit_end) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Counter restarts on every state change so each bit period starts from zero.
    always_comb begin
        if ((state_d != state_q) || bit_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            p_data_q <= 8'h00;
            busy_q   <= 1'b0;
            tx_out_q <= IDLE_LVL;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_data_q <= p_data_d;
            busy_q   <= busy_d;
            tx_out_q <= tx_out_d;
        end
    end

    assign ser_en = (state_q == StData);
    assign p_data = p_data_q;
    assign tx_out = tx_out_q;
    assign busy   = busy_q;

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, meaning clk cycles per UART bit (50 MHz / 9600 baud).
REQ-002 SHALL have parameter CLK_COUNTER_WIDTH, default $clog2(CLKS_PER_BIT), meaning the width of the bit-period counter.
REQ-003 SHALL have port clk, input, 1 bit: single system clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port data_valid, input, 1 bit: a byte is offered on p_data_in.
REQ-006 SHALL have port p_data_in, input, 8 bits: byte to transmit.
REQ-007 SHALL have port par_typ, input, 1 bit: parity type, 0 = even, 1 = odd. Present only with UART_PARITY_EN.
REQ-008 SHALL have port ser_data, input, 1 bit: serial bit from the downstream serializer.
REQ-009 SHALL have port ser_done, input, 1 bit: one-cycle pulse from the serializer when the last data bit has completed.
REQ-010 SHALL have port ser_en, output, 1 bit: enables the serializer.
REQ-011 SHALL have port p_data, output, 8 bits: latched byte presented to the serializer.
REQ-012 SHALL have port tx_out, output, 1 bit: UART line, idle high.
REQ-013 SHALL have port busy, output, 1 bit: a frame is in progress.

Function
REQ-014 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP.
REQ-015 In IDLE with data_valid=1, the block SHALL, on the same edge, latch p_data_in into p_data, compute the parity bit, set busy=1 and enter START.
REQ-016 data_valid SHALL be ignored whenever state != IDLE; no queuing.
REQ-017 START SHALL drive tx_out=0 for exactly CLKS_PER_BIT cycles, then enter DATA.
REQ-018 DATA SHALL assert ser_en=1 and pass ser_data to tx_out; on ser_done=1 it SHALL deassert ser_en and enter PARITY (UART_PARITY_EN) or STOP.
REQ-019 PARITY SHALL drive the parity bit for CLKS_PER_BIT cycles; even = XOR of p_data, odd = its inverse.
REQ-020 STOP SHALL drive tx_out=1 for CLKS_PER_BIT cycles, then enter IDLE and clear busy on that same edge.
REQ-021 tx_out SHALL be registered, with one-cycle latency from the state or ser_data change.
REQ-022 The bit-period counter SHALL clear on every state change and wrap at CLKS_PER_BIT-1, not at 2^CLK_COUNTER_WIDTH.
REQ-023 p_data SHALL remain stable from acceptance until the return to IDLE.
REQ-024 A ser_done pulse outside DATA SHALL be ignored.
REQ-025 data_valid=1 on the same edge that STOP completes SHALL NOT be accepted; it is accepted at the earliest on the next cycle in IDLE.
REQ-026 Frame length SHALL be (10 or 11)×CLKS_PER_BIT cycles plus serializer latency.

Reset
REQ-027 On reset assertion, regardless of clock, the block SHALL force state=IDLE, tx_out=1, busy=0, ser_en=0, p_data=8'h00, counter=0 and parity=0.
REQ-028 Reset mid-frame SHALL abort the frame immediately; the line returns high with no partial stop bit.
REQ-029 After reset deasserts, the first data_valid SHALL be accepted on the first rising edge.

Configuration
REQ-030 Macro UART_PARITY_EN SHALL control the parity feature: when defined, the par_typ port, the PARITY state and the parity register exist and frames are 11 bits.
REQ-031 When UART_PARITY_EN is undefined, DATA SHALL go directly to STOP, frames are 10 bits, and no parity logic is synthesized.

Structure
REQ-032 Package uart_pkg SHALL hold the state encoding typedef (3-bit), the default CLKS_PER_BIT and the constants IDLE_LVL=1, START_LVL=0 and STOP_LVL=1.
REQ-033 Parity generation SHALL be a sub-module parity_calc: 8-bit data and par_typ in, registered par_bit out, loaded on data_valid.
REQ-034 The serializer SHALL be instantiated outside this block; this block only drives ser_en and p_data and consumes ser_done and ser_data.

Verification (CLKS_PER_BIT=16 in bench)
REQ-035 Reset, then data_valid with 8'hA5 and no parity -> tx_out shows 0, 1,0,1,0,0,1,0,1 (LSB first), then 1; each bit 16 cycles; busy high for 160+ cycles.
REQ-036 UART_PARITY_EN with 8'hA5 and par_typ=0 -> parity bit=0; with par_typ=1 -> parity bit=1; frame 11 bits.
REQ-037 data_valid pulsed with 8'h3C mid-frame of 8'hA5 -> 8'h3C ignored; p_data stays 8'hA5; one frame only.
REQ-038 rst low during bit 4 of DATA -> tx_out=1, busy=0 and ser_en=0 within the same cycle; next data_valid starts a clean frame.
REQ-039 data_valid held high continuously -> back-to-back frames, each separated by at least one IDLE cycle, all bytes correct.
REQ-040 ser_done forced high during START -> no state change; START still lasts exactly 16 cycles.
